multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback.

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory and writeback sequencing.
// Optional memory wait timeout is enabled by defining MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic [1:0]  imm_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        instr_done,
  output logic        trap,
  output logic        trap_cause,
  output logic [2:0]  state
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StTrap   = 3'd6;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;

  // R and I share a class: both go EXEC->WB and differ only in the registered alu_src.
  localparam logic [1:0] ClsAlu   = 2'd0;
  localparam logic [1:0] ClsLoad  = 2'd1;
  localparam logic [1:0] ClsStore = 2'd2;
  localparam logic [1:0] ClsBr    = 2'd3;

  logic [2:0] state_q, state_d;
  logic [1:0] cls_q, cls_d;
  logic       bne_q, bne_d;
  logic [1:0] imm_sel_q, imm_sel_d;
  logic       alu_src_q, alu_src_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       timeout_hit;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    bne_d     = bne_q;
    imm_sel_d = imm_sel_q;
    alu_src_d = alu_src_q;
    alu_op_d  = alu_op_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) state_d = StTrap;
      end
      StDecode: begin
        state_d = StExec;
        case (instr[6:0])
          OpR: begin
            cls_d = ClsAlu; imm_sel_d = 2'b00; alu_src_d = 1'b0; alu_op_d = 2'b10;
          end
          OpI: begin
            cls_d = ClsAlu; imm_sel_d = 2'b00; alu_src_d = 1'b1; alu_op_d = 2'b10;
          end
          OpLoad: begin
            cls_d = ClsLoad; imm_sel_d = 2'b00; alu_src_d = 1'b1; alu_op_d = 2'b00;
          end
          OpStore: begin
            cls_d = ClsStore; imm_sel_d = 2'b01; alu_src_d = 1'b1; alu_op_d = 2'b00;
          end
          OpBr: begin
            // Only BEQ (000) and BNE (001) are supported.
            if (instr[14:13] == 2'b00) begin
              cls_d = ClsBr; bne_d = instr[12];
              imm_sel_d = 2'b10; alu_src_d = 1'b0; alu_op_d = 2'b01;
            end else begin
              state_d = StTrap;
            end
          end
          default: state_d = StTrap;
        endcase
      end
      StExec: begin
        unique case (cls_q)
          ClsAlu:            state_d = StWb;
          ClsLoad, ClsStore: state_d = StMem;
          ClsBr:             state_d = StFetch;
          default:           state_d = StFetch;
        endcase
      end
      StMem: begin
        if (mem_ready)        state_d = (cls_q == ClsLoad) ? StWb : StFetch;
        else if (timeout_hit) state_d = StTrap;
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsAlu;
      bne_q     <= 1'b0;
      imm_sel_q <= 2'b00;
      alu_src_q <= 1'b0;
      alu_op_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      bne_q     <= bne_d;
      imm_sel_q <= imm_sel_d;
      alu_src_q <= alu_src_d;
      alu_op_q  <= alu_op_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            trap_cause_q, trap_cause_d;

  // Trap on the wait cycle that brings the count to TIMEOUT_CYCLES; mem_ready that cycle wins.
  assign timeout_hit = mem_req && !mem_ready && (wait_cnt_q >= TimeoutLast);

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q | timeout_hit;
    if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
      wait_cnt_d = '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q   <= '0;
      trap_cause_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign trap_cause = trap_cause_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign trap_cause     = 1'b0;
`endif

  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  always_comb begin
    mem_req    = (state_q == StFetch) || (state_q == StMem);
    mem_we     = (state_q == StMem) && (cls_q == ClsStore);
    ir_write   = (state_q == StFetch) && mem_ready;
    pc_inc     = (state_q == StFetch) && mem_ready;
    pc_branch  = (state_q == StExec) && (cls_q == ClsBr) && (bne_q ? ~zero : zero);
    reg_write  = (state_q == StWb);
    wb_sel     = (state_q == StWb) && (cls_q == ClsLoad);
    instr_done = ((state_q == StExec) && (cls_q == ClsBr)) || (state_q == StWb) ||
                 ((state_q == StMem) && (cls_q == ClsStore) && mem_ready);
    trap       = (state_q == StTrap);
  end

  assign imm_sel = imm_sel_q;
  assign alu_src = alu_src_q;
  assign alu_op  = alu_op_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations are queued at issue and
// compared when the instruction completes. Define MEM_TIMEOUT_EN to exercise the timeout path.
module tb_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned Tmo = 4;
`else
  localparam int unsigned Tmo = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        mem_req, mem_we, ir_write, pc_inc, pc_branch;
  logic [1:0]  imm_sel, alu_op;
  logic        alu_src, reg_write, wb_sel, instr_done, trap, trap_cause;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .mem_ready (mem_ready),
    .zero      (zero),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_write  (ir_write),
    .pc_inc    (pc_inc),
    .pc_branch (pc_branch),
    .imm_sel   (imm_sel),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .instr_done(instr_done),
    .trap      (trap),
    .trap_cause(trap_cause),
    .state     (state)
  );

  typedef struct {
    logic [63:0] trace;
    int          cycles;
    int          reg_writes;
    logic        wb_sel;
    int          mem_we_cycles;
    int          branches;
    int          mem_reqs;
    logic [1:0]  imm_sel;
    logic [1:0]  alu_op;
    logic        alu_src;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [63:0] app(input logic [63:0] t, input int st);
    return (t << 3) | 64'(st);
  endfunction

  // Expected behaviour straight from the opcode table and latency rules.
  function automatic exp_t build_exp(input logic [31:0] ins, input logic z, input int fw,
                                     input int mw);
    exp_t e;
    e = '{trace: 64'd0, cycles: 0, reg_writes: 0, wb_sel: 1'b0, mem_we_cycles: 0,
          branches: 0, mem_reqs: fw + 1, imm_sel: 2'b00, alu_op: 2'b00, alu_src: 1'b0};
    for (int i = 0; i <= fw; i++) e.trace = app(e.trace, 1);
    e.trace = app(app(e.trace, 2), 3);
    e.cycles = fw + 3;
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        e.alu_op = 2'b10; e.alu_src = ins[4] && !ins[5];
        e.trace = app(e.trace, 5); e.cycles++; e.reg_writes = 1;
      end
      7'b0000011: begin
        e.alu_src = 1'b1;
        for (int i = 0; i <= mw; i++) e.trace = app(e.trace, 4);
        e.trace = app(e.trace, 5); e.cycles += mw + 2;
        e.reg_writes = 1; e.wb_sel = 1'b1; e.mem_reqs += mw + 1;
      end
      7'b0100011: begin
        e.imm_sel = 2'b01; e.alu_src = 1'b1;
        for (int i = 0; i <= mw; i++) e.trace = app(e.trace, 4);
        e.cycles += mw + 1; e.mem_we_cycles = mw + 1; e.mem_reqs += mw + 1;
      end
      default: begin
        e.imm_sel = 2'b10; e.alu_op = 2'b01;
        e.branches = (ins[12] ? !z : z) ? 1 : 0;
      end
    endcase
    return e;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw,
                           input string name);
    exp_t e;
    logic [63:0] trace = '0;
    int cycles = 0, irw = 0, pci = 0, both = 0, rw = 0, mwe = 0, br = 0, mreq = 0;
    int fcnt = 0, mcnt = 0;
    logic wbs = 1'b0, done = 1'b0;
    logic [1:0] imm_o = '0, op_o = '0;
    logic src_o = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL %s start_state: got %0d expected 1", name, state);
    end
    instr = ins; zero = z;
    sb_q.push_back(build_exp(ins, z, fw, mw));
    while (!done && cycles < 20) begin
      if (state == 3'd1) begin mem_ready = (fcnt >= fw); fcnt++; end
      else if (state == 3'd4) begin mem_ready = (mcnt >= mw); mcnt++; end
      else mem_ready = 1'($urandom_range(0, 1));
      #4;
      trace = app(trace, int'(state)); cycles++;
      irw += int'(ir_write); pci += int'(pc_inc); both += int'(ir_write && pc_inc);
      mwe += int'(mem_we); br += int'(pc_branch); mreq += int'(mem_req);
      if (reg_write) begin rw++; wbs = wb_sel; end
      if (instr_done) begin done = 1'b1; imm_o = imm_sel; op_o = alu_op; src_o = alu_src; end
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s done_timeout: got no instr_done expected within 20 cycles", name);
    end
    e = sb_q.pop_front();
    checks++;
    if (trace !== e.trace || cycles != e.cycles) begin
      errors++;
      $display("FAIL %s state_trace: got %0h (%0d cyc) expected %0h (%0d cyc)", name, trace,
               cycles, e.trace, e.cycles);
    end
    checks++;
    if (irw != 1 || pci != 1 || both != 1) begin
      errors++; $display("FAIL %s fetch_strobes: got ir_write=%0d pc_inc=%0d together=%0d expected 1/1/1",
                         name, irw, pci, both);
    end
    checks++;
    if (rw != e.reg_writes || wbs !== e.wb_sel) begin
      errors++; $display("FAIL %s reg_write: got %0d wb_sel=%0b expected %0d wb_sel=%0b", name, rw,
                         wbs, e.reg_writes, e.wb_sel);
    end
    checks++;
    if (mwe != e.mem_we_cycles || mreq != e.mem_reqs) begin
      errors++; $display("FAIL %s mem_strobes: got we=%0d req=%0d expected we=%0d req=%0d", name,
                         mwe, mreq, e.mem_we_cycles, e.mem_reqs);
    end
    checks++;
    if (br != e.branches) begin
      errors++; $display("FAIL %s pc_branch: got %0d expected %0d", name, br, e.branches);
    end
    checks++;
    if (imm_o !== e.imm_sel || op_o !== e.alu_op || src_o !== e.alu_src) begin
      errors++; $display("FAIL %s decode: got imm=%0b op=%0b src=%0b expected imm=%0b op=%0b src=%0b",
                         name, imm_o, op_o, src_o, e.imm_sel, e.alu_op, e.alu_src);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; instr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, ir_write, pc_inc, pc_branch, imm_sel, alu_src, alu_op, reg_write, wb_sel,
         instr_done, trap, trap_cause, state} !== 18'd0) begin
      errors++; $display("FAIL reset_outputs: got state=%0d mem_req=%0b trap=%0b expected all 0",
                         state, mem_req, trap);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #4;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got state=%0d mem_req=%0b expected 0/0", state, mem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd1 || mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_fetch: got state=%0d mem_req=%0b expected 1/1", state, mem_req);
    end
  endtask

  task automatic test_alu();
    run_instr(32'h002081B3, 1'b0, 0, 0, "add");
    run_instr(32'h00508093, 1'b1, 1, 0, "addi");
  endtask

  task automatic test_load_store();
    run_instr(32'h0000A183, 1'b0, 0, 3, "lw_wait3");
    run_instr(32'h0020A023, 1'b0, 0, 0, "sw");
    run_instr(32'h0020A023, 1'b1, 1, 2, "sw_wait2");
  endtask

  task automatic test_branch();
    run_instr(32'h00208463, 1'b1, 0, 0, "beq_taken");
    run_instr(32'h00208463, 1'b0, 0, 0, "beq_not");
    run_instr(32'h00209463, 1'b1, 0, 0, "bne_not");
    run_instr(32'h00209463, 1'b0, 0, 0, "bne_taken");
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [6];
    prog = '{32'h002081B3, 32'h0000A183, 32'h00208463, 32'h0020A023, 32'h00508093, 32'h00209463};
    for (int i = 0; i < 12; i++) begin
      run_instr(prog[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 2), "b2b");
    end
  endtask

  task automatic test_reset_midop();
    int n = 0;
    instr = 32'h0000A183; mem_ready = 1'b1;
    while (state != 3'd4 && n < 10) begin @(posedge clk); #1; n++; end
    mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_midop: got state=%0d mem_req=%0b expected 0/0", state, mem_req);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL reset_midop_restart: got state=%0d expected 1", state);
    end
  endtask

  task automatic test_illegal(input logic [31:0] ins, input string name);
    instr = ins; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd6 || trap !== 1'b1 || trap_cause !== 1'b0) begin
      errors++; $display("FAIL %s trap_entry: got state=%0d trap=%0b cause=%0b expected 6/1/0", name,
                         state, trap, trap_cause);
    end
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      #4;
      checks++;
      if (state !== 3'd6 || trap !== 1'b1 ||
          {mem_req, mem_we, ir_write, pc_inc, pc_branch, reg_write, instr_done} !== 7'd0) begin
        errors++; $display("FAIL %s trap_sticky: got state=%0d trap=%0b mem_req=%0b expected 6/1/0",
                           name, state, trap, mem_req);
      end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int waits = 0;
    mem_ready = 1'b0;
    while (state == 3'd1 && waits < 20) begin @(posedge clk); #1; waits++; end
    checks++;
    if (state !== 3'd6 || trap_cause !== 1'b1 || waits != 4) begin
      errors++; $display("FAIL timeout: got state=%0d cause=%0b waits=%0d expected 6/1/4", state,
                         trap_cause, waits);
    end
    do_reset();
  endtask
`else
  task automatic test_no_timeout();
    mem_ready = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd1 || trap !== 1'b0) begin
      errors++; $display("FAIL no_timeout: got state=%0d trap=%0b expected 1/0", state, trap);
    end
    run_instr(32'h002081B3, 1'b0, 0, 0, "add_after_wait");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_reset_midop();
    test_illegal(32'hFFFFFFFF, "illegal_opcode");
    test_illegal(32'h0020C463, "illegal_funct3");
    run_instr(32'h002081B3, 1'b0, 0, 0, "add_after_trap");
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
